// File: rtl/seven_seg_pkg.sv
// Shared types, blank pattern and hex-to-segment table for the seven-segment scan driver.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; entry 0 is the rightmost element of the concatenation.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  function automatic seg_t hex2seg(input logic [3:0] nibble);
    return HEX_SEG[nibble];
  endfunction

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// Host-side value/control inputs and board-side display pins of the scan driver.
interface seven_seg_scan_driver_if #(
  parameter int unsigned DIGITS = 8
);

  logic [4*DIGITS-1:0] values;
  logic                load;
  logic [DIGITS-1:0]   display_enable;
  logic [DIGITS-1:0]   dp;
  logic [3:0]          brightness;
  logic [6:0]          segments;
  logic                dp_n;
  logic [DIGITS-1:0]   anodes;
  logic                frame_tick;

  modport master (
    output values, load, display_enable, dp, brightness,
    input  segments, dp_n, anodes, frame_tick
  );

  modport slave (
    input  values, load, display_enable, dp, brightness,
    output segments, dp_n, anodes, frame_tick
  );

endinterface

// File: rtl/seven_seg_lzb.sv
// Leading-zero blank mask: digit i>0 is blanked when all enabled nibbles at or above i are zero.
module seven_seg_lzb #(
  parameter int unsigned DIGITS = 8
) (
  input  logic [4*DIGITS-1:0] active,
  input  logic [DIGITS-1:0]   display_enable,
  output logic [DIGITS-1:0]   blank_mask
);

  logic seen_nonzero;

  // Walk from the most significant digit down; digit 0 is never blanked.
  always_comb begin
    blank_mask   = '0;
    seen_nonzero = 1'b0;
    for (int unsigned i = DIGITS - 1; i > 0; i--) begin
      if (display_enable[i] && (active[4*i +: 4] != 4'h0)) begin
        seen_nonzero = 1'b1;
      end
      blank_mask[i] = ~seen_nonzero;
    end
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed hex scan driver: double-buffered values, decimal points, PWM brightness,
// frame strobe. Define SEVEN_SEG_LZB_EN to enable leading-zero blanking.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int unsigned DIGITS        = 8,
  parameter int unsigned SCAN_DIV_LOG2 = 14
) (
  input logic                   clk,
  input logic                   reset_n,
  seven_seg_scan_driver_if.slave bus
);

  localparam int unsigned      IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [SCAN_DIV_LOG2-1:0] prescaler;
  logic [IDX_W-1:0]         idx;
  logic [4*DIGITS-1:0]      shadow;
  logic [4*DIGITS-1:0]      active;
  logic                     pending;

  logic                     slot_end;
  logic                     boundary;
  logic [3:0]               duty_phase;
  logic                     lit;
  logic [DIGITS-1:0]        blank_mask;
  logic [DIGITS-1:0]        sel_onehot;
  logic [3:0]               nibble;

  logic [6:0]               segments_q;
  logic                     dp_n_q;
  logic [DIGITS-1:0]        anodes_q;
  logic                     frame_tick_q;

  assign slot_end   = &prescaler;
  assign boundary   = slot_end && (idx == LAST_IDX);
  assign duty_phase = prescaler[SCAN_DIV_LOG2-1 -: 4];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= '0;
      idx       <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
      if (slot_end) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
    end
  end

  // A load landing on the boundary cycle still commits the previous shadow and stays pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      if (boundary && pending) begin
        active <= shadow;
      end
      if (bus.load) begin
        shadow  <= bus.values;
        pending <= 1'b1;
      end else if (boundary) begin
        pending <= 1'b0;
      end
    end
  end

`ifdef SEVEN_SEG_LZB_EN
  seven_seg_lzb #(
    .DIGITS(DIGITS)
  ) u_lzb (
    .active        (active),
    .display_enable(bus.display_enable),
    .blank_mask    (blank_mask)
  );
`else
  assign blank_mask = '0;
`endif

  // Forcing dark on slot_end gives the one-cycle all-high gap at every idx change.
  always_comb begin
    sel_onehot      = '0;
    sel_onehot[idx] = 1'b1;
    nibble          = active[4*idx +: 4];
    lit             = bus.display_enable[idx] && (duty_phase <= bus.brightness)
                      && !slot_end && !blank_mask[idx];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      segments_q   <= SEG_BLANK;
      dp_n_q       <= 1'b1;
      anodes_q     <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      segments_q   <= lit ? hex2seg(nibble) : SEG_BLANK;
      dp_n_q       <= ~(lit && bus.dp[idx]);
      anodes_q     <= lit ? ~sel_onehot : '1;
      frame_tick_q <= boundary;
    end
  end

  assign bus.segments   = segments_q;
  assign bus.dp_n       = dp_n_q;
  assign bus.anodes     = anodes_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with DIGITS=8, SCAN_DIV_LOG2=4 (16-cycle slots).
module tb_seven_seg_scan_driver;

  localparam int unsigned DIGITS = 8;
  localparam int          FRAME  = DIGITS * 16;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  seven_seg_scan_driver_if #(.DIGITS(DIGITS)) bus ();

  seven_seg_scan_driver #(
    .DIGITS       (DIGITS),
    .SCAN_DIV_LOG2(4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_seen  [DIGITS];
  logic       dp_low    [DIGITS];
  int         low_cnt   [DIGITS];
  int         first_low [DIGITS];
  int         multi_low;
  int         mixed;
  int         tick_extra;
  int         dark_bad;

  function automatic logic [6:0] exp_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic wait_tick();
    for (int k = 0; k < 4 * FRAME && bus.frame_tick !== 1'b1; k++) @(negedge clk);
    n_tests++;
    if (bus.frame_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_tick_wait: actual %b required 1", bus.frame_tick);
    end
  endtask

  // Samples one frame starting at the frame_tick cycle; loads are driven at chosen positions.
  task automatic capture_frame(input bit do_sync,
                               input int at1, input logic [4*DIGITS-1:0] v1,
                               input int at2, input logic [4*DIGITS-1:0] v2);
    int nlow;
    if (do_sync) wait_tick();
    for (int d = 0; d < DIGITS; d++) begin
      seg_seen[d] = 7'h7F; dp_low[d] = 1'b0; low_cnt[d] = 0; first_low[d] = -1;
    end
    multi_low = 0; mixed = 0; tick_extra = 0; dark_bad = 0;
    for (int i = 0; i < FRAME; i++) begin
      bus.load = 1'b0;
      nlow = 0;
      for (int d = 0; d < DIGITS; d++) begin
        if (bus.anodes[d] === 1'b0) begin
          nlow++;
          if (low_cnt[d] > 0 && seg_seen[d] !== bus.segments) mixed++;
          seg_seen[d] = bus.segments;
          if (first_low[d] < 0) first_low[d] = i;
          low_cnt[d]++;
          if (bus.dp_n === 1'b0) dp_low[d] = 1'b1;
        end
      end
      if (nlow > 1) multi_low++;
      if (nlow == 0 && (bus.segments !== 7'h7F || bus.dp_n !== 1'b1)) dark_bad++;
      if (i > 0 && bus.frame_tick !== 1'b0) tick_extra++;
      if (i == at1) begin bus.values = v1; bus.load = 1'b1; end
      if (i == at2) begin bus.values = v2; bus.load = 1'b1; end
      @(negedge clk);
    end
    bus.load = 1'b0;
  endtask

  task automatic check_frame_shape(input string tag);
    n_tests++;
    if (multi_low != 0 || tick_extra != 0 || dark_bad != 0 || mixed != 0) begin
      n_fail++;
      $display("FAIL %s_shape: multi_low=%0d tick_extra=%0d dark_bad=%0d mixed=%0d required all 0",
               tag, multi_low, tick_extra, dark_bad, mixed);
    end
  endtask

  task automatic test_reset();
    bus.values = '0; bus.load = 1'b0;
    bus.display_enable = 8'hFF; bus.dp = 8'hFF; bus.brightness = 4'd15;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (50) @(negedge clk);
    n_tests++;
    if (bus.anodes === 8'hFF) begin
      n_fail++;
      $display("FAIL reset_pre_lit: anodes %h required a lit digit before reset", bus.anodes);
    end
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if (bus.anodes !== 8'hFF) begin n_fail++; $display("FAIL reset_async_anodes: actual %h required ff", bus.anodes); end
    n_tests++;
    if (bus.segments !== 7'h7F) begin n_fail++; $display("FAIL reset_async_segments: actual %h required 7f", bus.segments); end
    n_tests++;
    if (bus.dp_n !== 1'b1) begin n_fail++; $display("FAIL reset_async_dp_n: actual %b required 1", bus.dp_n); end
    n_tests++;
    if (bus.frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_async_tick: actual %b required 0", bus.frame_tick); end
    @(negedge clk);
    n_tests++;
    if (bus.anodes !== 8'hFF || bus.segments !== 7'h7F) begin
      n_fail++;
      $display("FAIL reset_hold: anodes %h segments %h required ff 7f", bus.anodes, bus.segments);
    end
    reset_n = 1'b1;
    capture_frame(1'b0, -1, '0, -1, '0);
    for (int d = 0; d < DIGITS; d++) begin
      n_tests++;
      if (first_low[d] != d * 16 + 1 || low_cnt[d] != 15 || seg_seen[d] !== 7'h40 || dp_low[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL sweep_digit%0d: first=%0d cnt=%0d seg=%h dp=%b required first=%0d cnt=15 seg=40 dp=1",
                 d, first_low[d], low_cnt[d], seg_seen[d], dp_low[d], d * 16 + 1);
      end
    end
    check_frame_shape("sweep");
    n_tests++;
    if (bus.frame_tick !== 1'b1) begin n_fail++; $display("FAIL sweep_period_tick: actual %b required 1", bus.frame_tick); end
  endtask

  task automatic test_load();
    logic [31:0] v;
    v = 32'h1234ABCD;
    bus.dp = 8'h00;
    capture_frame(1'b1, 10, v, -1, '0);
    for (int d = 0; d < DIGITS; d++) begin
      n_tests++;
      if (seg_seen[d] !== 7'h40 || dp_low[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL load_before_digit%0d: seg=%h dp=%b required 40 0", d, seg_seen[d], dp_low[d]);
      end
    end
    check_frame_shape("load_before");
    capture_frame(1'b1, -1, '0, -1, '0);
    n_tests++;
    if (seg_seen[0] !== 7'h21 || seg_seen[7] !== 7'h79) begin
      n_fail++;
      $display("FAIL load_ends: digit0=%h digit7=%h required 21 79", seg_seen[0], seg_seen[7]);
    end
    for (int d = 1; d < DIGITS - 1; d++) begin
      n_tests++;
      if (seg_seen[d] !== exp_seg(v[4*d +: 4])) begin
        n_fail++;
        $display("FAIL load_digit%0d: actual %h required %h", d, seg_seen[d], exp_seg(v[4*d +: 4]));
      end
    end
    check_frame_shape("load_after");
  endtask

  task automatic test_double_load();
    logic [31:0] v;
    v = 32'h1234ABCD;
    capture_frame(1'b1, 20, 32'h11111111, 70, 32'h22222222);
    for (int d = 0; d < DIGITS; d++) begin
      n_tests++;
      if (seg_seen[d] !== exp_seg(v[4*d +: 4])) begin
        n_fail++;
        $display("FAIL dbl_hold_digit%0d: actual %h required %h", d, seg_seen[d], exp_seg(v[4*d +: 4]));
      end
    end
    check_frame_shape("dbl_hold");
    capture_frame(1'b1, -1, '0, -1, '0);
    for (int d = 0; d < DIGITS; d++) begin
      n_tests++;
      if (seg_seen[d] !== 7'h24) begin
        n_fail++;
        $display("FAIL dbl_last_wins_digit%0d: actual %h required 24", d, seg_seen[d]);
      end
    end
  endtask

  task automatic test_coincident_load();
    logic [6:0] exp_frames [3];
    exp_frames = '{7'h24, 7'h12, 7'h02};
    capture_frame(1'b1, 30, 32'h55555555, FRAME - 1, 32'h66666666);
    for (int f = 0; f < 3; f++) begin
      if (f > 0) capture_frame(1'b1, -1, '0, -1, '0);
      for (int d = 0; d < DIGITS; d++) begin
        n_tests++;
        if (seg_seen[d] !== exp_frames[f]) begin
          n_fail++;
          $display("FAIL coincident_f%0d_digit%0d: actual %h required %h", f, d, seg_seen[d], exp_frames[f]);
        end
      end
    end
  endtask

  task automatic test_enable_dp_brightness();
    int cnt_lit [3];
    logic [3:0] levels [3];
    levels  = '{4'd3, 4'd15, 4'd0};
    cnt_lit = '{4, 15, 1};
    wait_tick();
    bus.display_enable = 8'h0F; bus.dp = 8'h02;
    for (int b = 0; b < 3; b++) begin
      bus.brightness = levels[b];
      capture_frame(1'b1, -1, '0, -1, '0);
      for (int d = 0; d < DIGITS; d++) begin
        n_tests++;
        if (low_cnt[d] != ((d < 4) ? cnt_lit[b] : 0)) begin
          n_fail++;
          $display("FAIL pwm_b%0d_digit%0d: low cycles %0d required %0d",
                   levels[b], d, low_cnt[d], (d < 4) ? cnt_lit[b] : 0);
        end
        n_tests++;
        if (dp_low[d] !== (d == 1) || (d < 4 && seg_seen[d] !== 7'h02)) begin
          n_fail++;
          $display("FAIL dp_b%0d_digit%0d: dp=%b seg=%h required dp=%b seg=02",
                   levels[b], d, dp_low[d], seg_seen[d], (d == 1));
        end
      end
      check_frame_shape("pwm");
    end
  endtask

  task automatic test_leading_zeros();
    logic [6:0] exp_seg_d [DIGITS];
    int         exp_cnt_d [DIGITS];
    wait_tick();
    bus.display_enable = 8'hFF; bus.dp = 8'h00; bus.brightness = 4'd15;
    for (int pass = 0; pass < 2; pass++) begin
      capture_frame(1'b1, 5, (pass == 0) ? 32'h000000A0 : 32'h00000000, -1, '0);
      capture_frame(1'b1, -1, '0, -1, '0);
      for (int d = 0; d < DIGITS; d++) begin
        exp_seg_d[d] = (pass == 0 && d == 1) ? 7'h08 : 7'h40;
`ifdef SEVEN_SEG_LZB_EN
        exp_cnt_d[d] = (d == 0 || (pass == 0 && d == 1)) ? 15 : 0;
        if (exp_cnt_d[d] == 0) exp_seg_d[d] = 7'h7F;
`else
        exp_cnt_d[d] = 15;
`endif
        n_tests++;
        if (low_cnt[d] != exp_cnt_d[d] || seg_seen[d] !== exp_seg_d[d]) begin
          n_fail++;
          $display("FAIL lzb_p%0d_digit%0d: cnt=%0d seg=%h required cnt=%0d seg=%h",
                   pass, d, low_cnt[d], seg_seen[d], exp_cnt_d[d], exp_seg_d[d]);
        end
      end
      check_frame_shape("lzb");
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_double_load();
    test_coincident_load();
    test_enable_dp_brightness();
    test_leading_zeros();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
